// File: rtl/debounce_pkg.sv
// Shared types and sizing helpers for the input debouncer and other pin conditioners.
package debounce_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    CONFIRM = 1'b1
  } db_state_t;

  // Width needed to hold the values 0..n.
  function automatic int cnt_width(int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_chain.sv
// Plain flop chain that brings an asynchronous pin into the clk domain.
module sync_chain #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] s;

  // Nothing sits between the stages so every flop gets a full cycle to resolve.
  always_ff @(posedge clk) begin
    if (reset) begin
      s <= {STAGES{RESET_VAL}};
    end else begin
      s <= {s[STAGES-2:0], d_i};
    end
  end

  assign q_o = s[STAGES-1];

endmodule

// File: rtl/input_debouncer.sv
// Synchronises a bouncy raw pin and only follows it after DEBOUNCE_CYCLES stable cycles.
module input_debouncer
  import debounce_pkg::*;
#(
  parameter int   SYNC_STAGES     = 2,
  parameter int   DEBOUNCE_CYCLES = 4,
  parameter logic RESET_VAL       = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic a_o,
  output logic busy_o,
  output logic change_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync_q;
  db_state_t        state;
  logic [CNT_W-1:0] cnt;
  logic             a_q;
  logic             change_q;

  sync_chain #(
    .STAGES    (SYNC_STAGES),
    .RESET_VAL (RESET_VAL)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d_i   (raw_i),
    .q_o   (sync_q)
  );

  // cnt counts cycles in which sync_q has differed from a_q; the first one is seen in IDLE.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= RESET_VAL;
      change_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (sync_q != a_q) begin
            if (DEBOUNCE_CYCLES == 1) begin
              a_q      <= sync_q;
              change_q <= 1'b1;
            end else begin
              state <= CONFIRM;
              cnt   <= CNT_ONE;
            end
          end
        end
        CONFIRM: begin
          if (sync_q == a_q) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state    <= IDLE;
            cnt      <= '0;
            a_q      <= sync_q;
            change_q <= 1'b1;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign a_o      = a_q;
  assign change_o = change_q;
  // busy_o doubles as the state debug view: the FSM has only two states.
  assign busy_o   = (state == CONFIRM);

endmodule

// File: tb/tb_input_debouncer.sv
// Directed bench for input_debouncer: default build plus a DEBOUNCE_CYCLES=1, RESET_VAL=1 build.
module tb_input_debouncer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic raw = 1'b1;
  logic raw_fast = 1'b1;
  logic a, busy, change;
  logic a_f, busy_f, change_f;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];

  input_debouncer u_dut (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (raw),
    .a_o      (a),
    .busy_o   (busy),
    .change_o (change)
  );

  input_debouncer #(
    .SYNC_STAGES     (2),
    .DEBOUNCE_CYCLES (1),
    .RESET_VAL       (1'b1)
  ) u_fast (
    .clk      (clk),
    .reset    (reset),
    .raw_i    (raw_fast),
    .a_o      (a_f),
    .busy_o   (busy_f),
    .change_o (change_f)
  );

  // clock / reset
  always #5 clk = ~clk;

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench just after the last reset edge, which counts as edge 0.
  task automatic do_reset();
    reset    = 1'b1;
    raw      = 1'b0;
    raw_fast = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  // scoreboard
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    logic r[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    logic a_prev;
    int   rises;
    int   pulses;

    // 1. reset held 3 cycles with raw high, then one cycle after release
    reset = 1'b1;
    raw   = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      tick();
      check($sformatf("rst_a_%0d", k), a, 0);
      check($sformatf("rst_busy_%0d", k), busy, 0);
      check($sformatf("rst_chg_%0d", k), change, 0);
    end
    check("rst_fast_a", a_f, 1);
    reset = 1'b0;
    tick();
    check("rst_after_a", a, 0);
    check("rst_after_busy", busy, 0);
    check("rst_after_chg", change, 0);

    // 2. clean step: a rises at edge 6, busy over edges 3..5
    do_reset();
    raw = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      exp_q.push_back({29'd0, (k == 6), (k >= 3 && k <= 5), (k >= 6)});
    end
    for (int k = 1; k <= 8; k++) begin
      logic [31:0] e;
      tick();
      e = exp_q.pop_front();
      check($sformatf("step_a_e%0d", k), a, e[0]);
      check($sformatf("step_busy_e%0d", k), busy, e[1]);
      check($sformatf("step_chg_e%0d", k), change, e[2]);
    end

    // 3. glitch: three synced high cycles never reach a
    do_reset();
    raw = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) raw = 1'b0;
      check($sformatf("glitch_a_e%0d", k), a, 0);
      check($sformatf("glitch_chg_e%0d", k), change, 0);
      check($sformatf("glitch_busy_e%0d", k), busy, (k >= 3 && k <= 5));
    end

    // 4. bounce: one rise, at edge 11 (4 cycles after the last synced 0)
    do_reset();
    raw    = r[0];
    a_prev = a;
    rises  = 0;
    pulses = 0;
    for (int k = 1; k <= 14; k++) exp_q.push_back({31'd0, (k >= 11)});
    for (int k = 1; k <= 14; k++) begin
      tick();
      raw = (k < 14) ? r[k] : 1'b1;
      check($sformatf("bounce_a_e%0d", k), a, exp_q.pop_front());
      if (a && !a_prev) rises++;
      if (change) pulses++;
      a_prev = a;
    end
    check("bounce_rises", rises, 1);
    check("bounce_pulses", pulses, 1);

    // 5. reset sampled at edge 5 while in CONFIRM; a rises only at edge 11
    do_reset();
    raw = 1'b1;
    for (int k = 1; k <= 4; k++) tick();
    check("midrst_busy_e4", busy, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_a_e5", a, 0);
    check("midrst_busy_e5", busy, 0);
    check("midrst_chg_e5", change, 0);
    for (int k = 6; k <= 12; k++) begin
      tick();
      check($sformatf("midrst_a_e%0d", k), a, (k >= 11));
      check($sformatf("midrst_chg_e%0d", k), change, (k == 11));
    end

    // 6. DEBOUNCE_CYCLES=1 build: falling step commits at edge 3
    do_reset();
    raw_fast = 1'b0;
    pulses   = 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (change_f) pulses++;
      check($sformatf("fast_a_e%0d", k), a_f, (k < 3));
      check($sformatf("fast_chg_e%0d", k), change_f, (k == 3));
      check($sformatf("fast_busy_e%0d", k), busy_f, 0);
    end
    check("fast_pulses", pulses, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
